// File: rtl/fb_scanout_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fb_scanout_reader
//  Purpose  : Display-side prefetch stage. Walks the framebuffer linearly,
//             issues single-word reads to the SDRAM controller word interface
//             (idle/acc/ack handshake) and buffers the returned RGB444 words
//             in a first-word-fall-through FIFO that the pixel path pops.
//  Ports    :
//     clk          pixel/SDRAM clock
//     reset_n_i    asynchronous active-low reset
//     frame_i      start-of-frame pulse; flushes FIFO and restarts the walk
//     sc_idle_i    controller ready for a new access
//     sc_adr_o     word address of the current access
//     sc_acc_o     access request, held until sc_ack_i
//     sc_we_o      write enable, tied low (read-only client)
//     sc_ack_i     one-cycle completion strobe, sc_dat_i valid
//     sc_dat_i     read data
//     rd_i         pop the head word
//     data_o       registered FIFO head word
//     valid_o      FIFO not empty
//     level_o      FIFO occupancy
//     underflow_o  sticky pop-while-empty flag, cleared by frame_i
//  Revision : 1.0  initial release
// ============================================================================
module fb_scanout_reader #(
   parameter int          FB_WIDTH   = 128,
   parameter int          FB_HEIGHT  = 128,
   parameter logic [31:0] BASE_ADDR  = 32'd0,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic                            clk,
   input  logic                            reset_n_i,
   input  logic                            frame_i,
   input  logic                            sc_idle_i,
   output logic [31:0]                     sc_adr_o,
   output logic                            sc_acc_o,
   output logic                            sc_we_o,
   input  logic                            sc_ack_i,
   input  logic [15:0]                     sc_dat_i,
   input  logic                            rd_i,
   output logic [15:0]                     data_o,
   output logic                            valid_o,
   output logic [$clog2(FIFO_DEPTH):0]     level_o,
   output logic                            underflow_o
);

   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                LVL_W     = PTR_W + 1;
   localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  ONE_LVL   = LVL_W'(1);
   localparam logic [31:0]       LAST_IDX  = 32'(FB_WIDTH * FB_HEIGHT - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   logic [1:0]        state;
   logic [31:0]       idx;
   logic [31:0]       idx_next;
   logic [15:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [LVL_W-1:0]  level;
   logic              push;
   logic              pop;

   assign sc_we_o     = 1'b0;
   assign level_o     = level;
   assign valid_o     = (level != '0);
   assign rd_ptr_next = rd_ptr + 1'b1;
   assign idx_next    = (idx == LAST_IDX) ? 32'd0 : idx + 32'd1;

   // frame_i wins over both push and pop in the same cycle.
   assign push = (state == ST_REQ) && sc_ack_i && !frame_i;
   assign pop  = rd_i && valid_o && !frame_i;

   // Storage array carries no reset; only occupied entries are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= sc_dat_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state       <= ST_IDLE;
         idx         <= '0;
         sc_acc_o    <= 1'b0;
         sc_adr_o    <= BASE_ADDR;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         data_o      <= '0;
         underflow_o <= 1'b0;
      end else begin
         // ---------------- FIFO pointers / occupancy ----------------
         if (frame_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr_next;
            if (push && !pop)      level <= level + ONE_LVL;
            else if (pop && !push) level <= level - ONE_LVL;
         end

         // ---------------- registered head word ----------------
         // With a single entry being popped while a word arrives, the array
         // slot behind the head is not yet written, so the incoming word is
         // forwarded straight to the head register.
         if (!frame_i) begin
            if (pop) begin
               if (level > ONE_LVL) data_o <= mem[rd_ptr_next];
               else if (push)       data_o <= sc_dat_i;
            end else if (push && (level == '0)) begin
               data_o <= sc_dat_i;
            end
         end

         // ---------------- sticky underflow ----------------
         if (frame_i)               underflow_o <= 1'b0;
         else if (rd_i && !valid_o) underflow_o <= 1'b1;

         // ---------------- access sequencer ----------------
         if (frame_i) idx <= '0;

         case (state)
            ST_IDLE: begin
               if (sc_idle_i && (level < DEPTH_LVL) && !frame_i) begin
                  sc_acc_o <= 1'b1;
                  sc_adr_o <= BASE_ADDR + idx;
                  state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (sc_ack_i) begin
                  sc_acc_o <= 1'b0;
                  state    <= ST_IDLE;
                  if (!frame_i) idx <= idx_next;
               end else if (frame_i) begin
                  // The controller cannot abort, so the request stays up and
                  // the stale word is swallowed when it arrives.
                  state <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (sc_ack_i) begin
                  sc_acc_o <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               sc_acc_o <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_scanout_reader
//  Purpose  : Self-checking bench for fb_scanout_reader. A controller
//             responder and a queue-based model of the prefetch FIFO, the
//             framebuffer walk and the underflow flag run alongside the DUT.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_scanout_reader;

   localparam int          FBW   = 8;
   localparam int          FBH   = 4;
   localparam int          NW    = FBW * FBH;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset_n_i;
   logic        frame_i;
   logic        sc_idle_i;
   logic [31:0] sc_adr_o;
   logic        sc_acc_o;
   logic        sc_we_o;
   logic        sc_ack_i;
   logic [15:0] sc_dat_i;
   logic        rd_i;
   logic [15:0] data_o;
   logic        valid_o;
   logic [4:0]  level_o;
   logic        underflow_o;

   fb_scanout_reader #(
      .FB_WIDTH   (FBW),
      .FB_HEIGHT  (FBH),
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset_n_i   (reset_n_i),
      .frame_i     (frame_i),
      .sc_idle_i   (sc_idle_i),
      .sc_adr_o    (sc_adr_o),
      .sc_acc_o    (sc_acc_o),
      .sc_we_o     (sc_we_o),
      .sc_ack_i    (sc_ack_i),
      .sc_dat_i    (sc_dat_i),
      .rd_i        (rd_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .level_o     (level_o),
      .underflow_o (underflow_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0]  q[$];
   logic [31:0]  adr_log[$];
   int unsigned  idx = 0;
   bit           m_uf = 1'b0;
   bit           outstanding = 1'b0;
   bit           killed = 1'b0;
   logic [31:0]  cur_adr = '0;
   int           wcnt = 0;
   int           delay = 1;
   int           acc_count = 0;
   bit           prev_ok = 1'b0;

   // Stimulus knobs
   int idle_mode = 0;   // 0 never, 1 always, 2 random
   int rd_mode   = 0;   // 0 never, 1 always, 2 random
   bit ack_rand  = 1'b0;
   int ack_fix   = 3;
   bit rand_data = 1'b0;
   bit frame_req = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      idx         = 0;
      m_uf        = 1'b0;
      outstanding = 1'b0;
      killed      = 1'b0;
      prev_ok     = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, drive inputs for the next
   // rising edge, then advance the model by what that edge will do.
   task automatic cycle();
      logic [15:0] d;
      logic        fr, rdv, idl, ack;
      int          sz;
      @(negedge clk);
      sz = q.size();
      chk("level", level_o, sz);
      chk("valid", valid_o, (sz != 0));
      chk("underflow", underflow_o, m_uf);
      chk("we", sc_we_o, 1'b0);
      if (sz != 0) chk("data", data_o, q[0]);

      if (sc_acc_o === 1'b1 && !outstanding) begin
         chk("issue_ok", prev_ok, 1'b1);
         chk("acc_adr", sc_adr_o, BASE + idx);
         outstanding = 1'b1;
         killed      = 1'b0;
         cur_adr     = sc_adr_o;
         wcnt        = 0;
         delay       = ack_rand ? int'($urandom_range(1, 6)) : ack_fix;
         acc_count++;
         adr_log.push_back(sc_adr_o);
      end else if (outstanding) begin
         chk("acc_held", sc_acc_o, 1'b1);
         chk("adr_stable", sc_adr_o, cur_adr);
      end else begin
         chk("acc_low", sc_acc_o, 1'b0);
      end

      fr = frame_req;
      frame_req = 1'b0;
      case (rd_mode)
         0:       rdv = 1'b0;
         1:       rdv = 1'b1;
         default: rdv = ($urandom_range(0, 2) == 0);
      endcase
      case (idle_mode)
         0:       idl = 1'b0;
         1:       idl = 1'b1;
         default: idl = ($urandom_range(0, 3) != 0);
      endcase
      ack = 1'b0;
      if (outstanding) begin
         wcnt++;
         if (wcnt >= delay) ack = 1'b1;
      end
      d = (ack && !rand_data) ? cur_adr[15:0] : 16'($urandom);

      frame_i   = fr;
      rd_i      = rdv;
      sc_idle_i = idl;
      sc_ack_i  = ack;
      sc_dat_i  = d;

      prev_ok = (sc_acc_o === 1'b0) && idl && (sz < DEPTH) && !fr;

      if (fr) begin
         q.delete();
         idx  = 0;
         m_uf = 1'b0;
         if (ack) begin
            outstanding = 1'b0;
            killed      = 1'b0;
         end else if (outstanding) begin
            killed = 1'b1;
         end
      end else begin
         if (rdv) begin
            if (q.size() > 0) void'(q.pop_front());
            else              m_uf = 1'b1;
         end
         if (ack) begin
            if (!killed) begin
               q.push_back(d);
               idx = (idx + 1) % NW;
            end
            outstanding = 1'b0;
            killed      = 1'b0;
         end
      end
   endtask

   initial begin
      int  n0;
      bit  found;

      // ---------------- reset ----------------
      reset_n_i = 1'b0;
      frame_i   = 1'b0;
      sc_idle_i = 1'b0;
      sc_ack_i  = 1'b0;
      sc_dat_i  = '0;
      rd_i      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_acc", sc_acc_o, 1'b0);
      chk("rst_adr", sc_adr_o, BASE);
      chk("rst_we", sc_we_o, 1'b0);
      chk("rst_data", data_o, 16'h0000);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_level", level_o, 0);
      chk("rst_uf", underflow_o, 1'b0);
      reset_n_i = 1'b1;
      model_reset();

      // ---------------- fill with no pops ----------------
      idle_mode = 1; rd_mode = 0; ack_rand = 1'b0; ack_fix = 3; rand_data = 1'b0;
      repeat (120) cycle();
      chk("fill_count", acc_count, 16);
      chk("fill_level", level_o, 16);
      chk("fill_head", data_o, 16'h1000);
      chk("fill_acc_off", sc_acc_o, 1'b0);

      // ---------------- pop every cycle from full ----------------
      ack_fix = 1;
      rd_mode = 1;
      repeat (20) cycle();
      rd_mode = 0;
      cycle();
      chk("pop_no_uf", underflow_o, 1'b0);
      found = (adr_log.size() > 16);
      chk("refill_seen", found, 1'b1);
      if (found) chk("refill_adr", adr_log[16], BASE + 32'd16);

      // ---------------- random traffic, wrap without frame ----------------
      idle_mode = 2; rd_mode = 2; ack_rand = 1'b1; rand_data = 1'b1;
      repeat (400) cycle();
      found = (adr_log.size() > 32);
      chk("wrap_seen", found, 1'b1);
      if (found) begin
         chk("wrap_last", adr_log[31], BASE + 32'd31);
         chk("wrap_first", adr_log[32], BASE);
      end

      // ---------------- frame during REQ ----------------
      idle_mode = 1; rd_mode = 0; ack_rand = 1'b0; ack_fix = 5;
      frame_req = 1'b1;
      cycle();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle();
         found = outstanding && !killed && (wcnt == 1);
      end
      chk("wait_req", found, 1'b1);
      frame_req = 1'b1;
      n0 = acc_count;
      cycle();
      cycle();
      chk("flush_level", level_o, 0);
      chk("flush_valid", valid_o, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         cycle();
         found = (acc_count > n0);
      end
      chk("wait_reissue", found, 1'b1);
      if (found) chk("reissue_adr", adr_log[adr_log.size()-1], BASE);

      // ---------------- idle low, drain, underflow ----------------
      idle_mode = 0; rd_mode = 1;
      repeat (8) cycle();
      n0 = acc_count;
      repeat (50) cycle();
      chk("idle_no_acc", acc_count, n0);
      chk("uf_set", underflow_o, 1'b1);
      rd_mode = 0;
      repeat (5) cycle();
      chk("uf_sticky", underflow_o, 1'b1);
      chk("uf_level", level_o, 0);
      frame_req = 1'b1;
      cycle();
      cycle();
      chk("uf_clear", underflow_o, 1'b0);

      // ---------------- random traffic with random frames ----------------
      idle_mode = 2; rd_mode = 2; ack_rand = 1'b1; rand_data = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 29) == 0) frame_req = 1'b1;
         cycle();
      end

      // ---------------- asynchronous reset mid-access ----------------
      idle_mode = 1; rd_mode = 0; ack_rand = 1'b0; ack_fix = 6;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         cycle();
         found = (sc_acc_o === 1'b1);
      end
      chk("wait_acc", found, 1'b1);
      #2 reset_n_i = 1'b0;
      #1;
      chk("arst_acc", sc_acc_o, 1'b0);
      chk("arst_adr", sc_adr_o, BASE);
      chk("arst_data", data_o, 16'h0000);
      chk("arst_valid", valid_o, 1'b0);
      chk("arst_level", level_o, 0);
      chk("arst_uf", underflow_o, 1'b0);
      sc_idle_i = 1'b0;
      sc_ack_i  = 1'b0;
      rd_i      = 1'b0;
      frame_i   = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n_i = 1'b1;
      ack_fix = 2;
      n0 = acc_count;
      repeat (30) cycle();
      found = (acc_count > n0);
      chk("post_rst_acc", found, 1'b1);
      if (found) chk("post_rst_adr", adr_log[n0], BASE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
